// File: rtl/sensor_rx_pkg.sv
// Shared types and defaults for the sensor readout deserialiser.
//   rx_state_t       : receiver state (IDLE / HUNT / RX)
//   SYNC_*_DEFAULT   : default sync words for start-of-frame and start-of-line
//   pix_word_t       : 16-bit pixel word as carried on the AXI4-Stream bus
package sensor_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    RX
  } rx_state_t;

  localparam logic [15:0] SYNC_SOF_DEFAULT = 16'hA5C3;
  localparam logic [15:0] SYNC_SOL_DEFAULT = 16'h5A3C;

  typedef logic [15:0] pix_word_t;

endpackage

// File: rtl/sensor_lane_shift.sv
// One serial readout lane: input register plus MSB-first shift register.
//   clk, rst   : system clock, synchronous active-high reset
//   clr        : clears the shift history
//   shift_en   : shift the registered lane bit in this cycle
//   lane_in    : raw serial lane
//   sync_word  : last SYNC_W bits including the bit being shifted now
//   pixel      : last PIX_W bits including the bit being shifted now
module sensor_lane_shift
  import sensor_rx_pkg::*;
#(
  parameter int PIX_W  = 14,
  parameter int SYNC_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              lane_in,
  output logic [SYNC_W-1:0] sync_word,
  output logic [PIX_W-1:0]  pixel
);

  localparam int SR_W = (PIX_W > SYNC_W) ? PIX_W : SYNC_W;

  logic            lane_q;
  logic [SR_W-2:0] hist;
  logic [SR_W-1:0] shifted;

  // Outputs present the post-shift word so the caller can act on the same
  // strobe cycle that delivers the final bit.
  assign shifted   = {hist, lane_q};
  assign sync_word = shifted[SYNC_W-1:0];
  assign pixel     = shifted[PIX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) lane_q <= 1'b0;
    else     lane_q <= lane_in;
  end

  always_ff @(posedge clk) begin
    if (rst || clr)    hist <= '0;
    else if (shift_en) hist <= shifted[SR_W-2:0];
  end

endmodule

// File: rtl/sensor_rx_deser.sv
// Two-lane IR sensor readout deserialiser to a 16-bit AXI4-Stream pixel stream.
//   clk, rst                 : system clock, synchronous active-high reset
//   enable                   : receiver enable, low forces IDLE
//   bit_stb                  : lane sample strobe
//   sensor_data_even/odd     : serial lanes (even / odd columns)
//   m_axis_t*                : pixel stream; tuser = first pixel of frame,
//                              tlast = last pixel of line
//   line_active              : high while receiving line pixels
//   overflow / overflow_clr  : sticky dropped-pair flag and its clear
module sensor_rx_deser
  import sensor_rx_pkg::*;
#(
  parameter int              PIX_W       = 14,
  parameter int              SYNC_W      = 16,
  parameter logic [SYNC_W-1:0] SYNC_SOF  = SYNC_W'(SYNC_SOF_DEFAULT),
  parameter logic [SYNC_W-1:0] SYNC_SOL  = SYNC_W'(SYNC_SOL_DEFAULT),
  parameter int              LINE_PIXELS = 384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        bit_stb,
  input  logic        sensor_data_even,
  input  logic        sensor_data_odd,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        line_active,
  output logic        overflow,
  input  logic        overflow_clr
);

  localparam int SR_W  = (PIX_W > SYNC_W) ? PIX_W : SYNC_W;
  localparam int BIT_W = $clog2(SR_W);
  localparam int PAIRS = LINE_PIXELS / 2;
  localparam int CNT_W = $clog2(PAIRS + 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(PIX_W - 1);
  localparam logic [CNT_W-1:0] PAIR_LAST = CNT_W'(PAIRS - 1);

  rx_state_t         state, state_nxt;
  logic              shift_en, lane_clr;
  logic [SYNC_W-1:0] even_sync, odd_sync;
  logic [PIX_W-1:0]  even_pix_new, odd_pix_new;
  logic [BIT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  pair_cnt;
  logic              sof_pending;
  logic              hunt_stb, rx_stb, sof_hit, sol_hit;
  logic              pair_done, pair_last, buf_free, push, drop, hs;
  logic              even_vld, odd_vld, even_user, odd_last;
  pix_word_t         even_word, odd_word;

  sensor_lane_shift #(.PIX_W(PIX_W), .SYNC_W(SYNC_W)) u_lane_even (
    .clk(clk), .rst(rst), .clr(lane_clr), .shift_en(shift_en),
    .lane_in(sensor_data_even), .sync_word(even_sync), .pixel(even_pix_new)
  );

  sensor_lane_shift #(.PIX_W(PIX_W), .SYNC_W(SYNC_W)) u_lane_odd (
    .clk(clk), .rst(rst), .clr(lane_clr), .shift_en(shift_en),
    .lane_in(sensor_data_odd), .sync_word(odd_sync), .pixel(odd_pix_new)
  );

  assign hunt_stb  = enable && bit_stb && (state == HUNT);
  assign rx_stb    = enable && bit_stb && (state == RX);
  assign sof_hit   = hunt_stb && (even_sync == SYNC_SOF) && (odd_sync == SYNC_SOF);
  assign sol_hit   = hunt_stb && (even_sync == SYNC_SOL) && (odd_sync == SYNC_SOL);
  assign pair_done = rx_stb && (bit_cnt == BIT_LAST);
  assign pair_last = (pair_cnt == PAIR_LAST);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_nxt = HUNT;
        HUNT:    if (sof_hit || sol_hit) state_nxt = RX;
        RX:      if (pair_done && pair_last) state_nxt = HUNT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    line_active = (state == RX);
    shift_en    = bit_stb && (state != IDLE);
    lane_clr    = (state == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst || !enable || state != RX) bit_cnt <= '0;
    else if (bit_stb)                  bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
  end

  // Dropped pairs still advance pair_cnt so the line end stays aligned.
  always_ff @(posedge clk) begin
    if (rst || !enable || state != RX) pair_cnt <= '0;
    else if (pair_done)                pair_cnt <= pair_last ? '0 : pair_cnt + 1'b1;
  end

  // Cleared on the accepted push rather than the handshake: until the even
  // beat is taken no further pair can enter, so the result is identical.
  always_ff @(posedge clk) begin
    if (rst || !enable || state == IDLE) sof_pending <= 1'b0;
    else if (sof_hit)                    sof_pending <= 1'b1;
    else if (push)                       sof_pending <= 1'b0;
  end

  // Pair buffer: the even slot drains first, then the odd slot. A new pair
  // may enter only when the last held beat leaves in this same cycle.
  assign hs       = m_axis_tvalid && m_axis_tready;
  assign buf_free = !even_vld && (!odd_vld || hs);
  assign push     = pair_done && buf_free;
  assign drop     = pair_done && !buf_free;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      even_vld <= 1'b0;
      odd_vld  <= 1'b0;
    end else if (push) begin
      even_vld <= 1'b1;
      odd_vld  <= 1'b1;
    end else if (hs) begin
      if (even_vld) even_vld <= 1'b0;
      else          odd_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      even_word <= '0;
      odd_word  <= '0;
      even_user <= 1'b0;
      odd_last  <= 1'b0;
    end else if (push) begin
      even_word <= pix_word_t'(even_pix_new);
      odd_word  <= pix_word_t'(odd_pix_new);
      even_user <= sof_pending;
      odd_last  <= pair_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)               overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

  assign m_axis_tvalid = even_vld || odd_vld;
  assign m_axis_tdata  = even_vld ? even_word : (odd_vld ? odd_word : '0);
  assign m_axis_tuser  = even_vld && even_user;
  assign m_axis_tlast  = !even_vld && odd_vld && odd_last;

endmodule

// File: tb/tb_sensor_rx_deser.sv
module tb_sensor_rx_deser;

  localparam int PIX_W       = 14;
  localparam int LINE_PIXELS = 8;
  localparam int NP          = LINE_PIXELS / 2;
  localparam logic [15:0] SOF = 16'hA5C3;
  localparam logic [15:0] SOL = 16'h5A3C;

  logic        clk = 1'b0;
  logic        rst, enable, bit_stb, se, so, tready, ovf_clr;
  logic [15:0] tdata;
  logic        tvalid, tuser, tlast, line_active, overflow;

  sensor_rx_deser #(.PIX_W(PIX_W), .LINE_PIXELS(LINE_PIXELS)) dut (
    .clk(clk), .rst(rst), .enable(enable), .bit_stb(bit_stb),
    .sensor_data_even(se), .sensor_data_odd(so),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tuser(tuser), .m_axis_tlast(tlast), .line_active(line_active),
    .overflow(overflow), .overflow_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Stimulus bit stream; events attach to the strobe that delivers the bit.
  typedef struct {
    logic        e, o;
    int          sync_ev;   // 0 none, 1 SOF match, 2 SOL match
    bit          pair_ev, last, clr, rdy_on;
    logic [15:0] pe, po;
  } bit_t;
  bit_t bq[$];

  typedef struct { logic [15:0] d; logic u; logic l; } beat_t;
  beat_t       mq[$];          // beats the DUT must present, in order
  logic [15:0] obs[$];         // beats the DUT actually handed over
  int          n_beats, n_user, n_last;

  int          ev_sync;
  bit          ev_pair, ev_last, mdl_on, rdy_rand;
  logic [15:0] ev_even, ev_odd;
  bit          m_sof, m_ovf, m_rx;

  // Transaction-level reference: expected beat queue, sticky overflow,
  // pending-SOF flag and line-active flag, advanced once per cycle.
  always @(negedge clk) begin
    if (mdl_on) begin
      bit drop;
      check_eq("tvalid", tvalid, mq.size() != 0);
      if (mq.size() != 0) begin
        check_eq("tdata", tdata, mq[0].d);
        check_eq("tuser", tuser, mq[0].u);
        check_eq("tlast", tlast, mq[0].l);
      end
      check_eq("line_active", line_active, m_rx);
      check_eq("overflow", overflow, m_ovf);
      if (tvalid && tready) begin
        obs.push_back(tdata);
        n_beats++;
        n_user += int'(tuser);
        n_last += int'(tlast);
      end
      drop = 1'b0;
      if (rst) begin
        mq.delete(); m_sof = 0; m_ovf = 0; m_rx = 0;
      end else if (!enable) begin
        mq.delete(); m_sof = 0; m_rx = 0;
        if (ovf_clr) m_ovf = 0;
      end else begin
        if (mq.size() != 0 && tready) void'(mq.pop_front());
        if (ev_sync != 0) begin
          m_rx = 1;
          if (ev_sync == 1) m_sof = 1;
        end
        if (ev_pair) begin
          if (mq.size() != 0) drop = 1'b1;
          else begin
            mq.push_back('{d: ev_even, u: m_sof, l: 1'b0});
            mq.push_back('{d: ev_odd,  u: 1'b0,  l: ev_last});
            m_sof = 0;
          end
          if (ev_last) m_rx = 0;
        end
        if (drop)         m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bit_stb = 1'b0; ev_sync = 0; ev_pair = 1'b0; ev_last = 1'b0; ovf_clr = 1'b0;
    if (rdy_rand) tready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic add_word(input logic [15:0] we, input logic [15:0] wo, input int n,
                          input int sev, input bit pev, input bit last, input bit clr, input bit rdy);
    for (int b = n - 1; b >= 0; b--) begin
      bit_t x;
      x.e = we[b]; x.o = wo[b];
      x.sync_ev = (b == 0) ? sev : 0;
      x.pair_ev = (b == 0) && pev;
      x.last    = (b == 0) && last;
      x.clr     = (b == 0) && clr;
      x.rdy_on  = (b == 0) && rdy;
      x.pe = we; x.po = wo;
      bq.push_back(x);
    end
  endtask

  task automatic add_pair(input logic [15:0] pe, input logic [15:0] po, input bit last,
                          input bit clr, input bit rdy);
    add_word(pe, po, PIX_W, 0, 1'b1, last, clr, rdy);
  endtask

  function automatic logic [15:0] rnd_pix();
    return 16'($urandom_range(0, (1 << PIX_W) - 1));
  endfunction

  task automatic add_line(input int sev, input int clr_pair, input int rdy_pair);
    logic [15:0] sw;
    sw = (sev == 1) ? SOF : SOL;
    add_word(sw, sw, 16, sev, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int p = 0; p < NP; p++)
      add_pair(rnd_pix(), rnd_pix(), p == NP - 1, p == clr_pair, p == rdy_pair);
  endtask

  task automatic add_garbage(input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] g;
      g = 16'($urandom);
      add_word(g, ~g, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Lane data leads its strobe by one cycle because the DUT registers lanes.
  task automatic play(input int gap);
    int n;
    n = bq.size();
    for (int i = 0; i <= n; i++) begin
      int g;
      if (i < n) begin se = bq[i].e; so = bq[i].o; end
      else begin se = 1'($urandom); so = 1'($urandom); end
      if (i > 0) begin
        bit_stb = 1'b1;
        ev_sync = bq[i-1].sync_ev;
        ev_pair = bq[i-1].pair_ev;
        ev_last = bq[i-1].last;
        ev_even = bq[i-1].pe;
        ev_odd  = bq[i-1].po;
        if (bq[i-1].clr)    ovf_clr = 1'b1;
        if (bq[i-1].rdy_on) tready  = 1'b1;
      end
      tick();
      g = (gap == 0) ? $urandom_range(1, 3) : gap;
      for (int k = 1; k < g; k++) tick();
    end
    bq.delete();
  endtask

  task automatic drain();
    int k;
    rdy_rand = 1'b0;
    tready   = 1'b1;
    k = 0;
    while ((mq.size() != 0 || tvalid) && k < 100) begin
      tick();
      k++;
    end
    check_eq("drain_done", tvalid, 1'b0);
    tick();
  endtask

  task automatic clear_stats();
    obs.delete();
    n_beats = 0; n_user = 0; n_last = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enable = 1'b0; bit_stb = 1'b0; se = 1'b0; so = 1'b0;
    tready = 1'b1; ovf_clr = 1'b0; rdy_rand = 1'b0;
    ev_sync = 0; ev_pair = 1'b0; ev_last = 1'b0; ev_even = '0; ev_odd = '0;
    m_sof = 0; m_ovf = 0; m_rx = 0; mdl_on = 1'b0;
    clear_stats();
    tick();
    mdl_on = 1'b1;
    tick(); tick();
    check_eq("rst_tvalid", tvalid, 1'b0);
    check_eq("rst_tdata", tdata, 16'h0);
    check_eq("rst_overflow", overflow, 1'b0);
    check_eq("rst_line_active", line_active, 1'b0);
    rst = 1'b0; enable = 1'b1;
    tick();

    // SOF line with fixed pixels, strobe every 2nd cycle
    clear_stats();
    add_word(SOF, SOF, 16, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int p = 0; p < NP; p++)
      add_pair(16'(p + 1), 16'(16'h3FFF - p), p == NP - 1, 1'b0, 1'b0);
    play(2);
    drain();
    check_eq("t1_beats", n_beats, 8);
    check_eq("t1_tuser", n_user, 1);
    check_eq("t1_tlast", n_last, 1);
    if (obs.size() == 8) begin
      check_eq("t1_beat0", obs[0], 16'h0001);
      check_eq("t1_beat1", obs[1], 16'h3FFF);
      check_eq("t1_beat2", obs[2], 16'h0002);
      check_eq("t1_beat7", obs[7], 16'h3FFC);
    end
    check_eq("t1_overflow", overflow, 1'b0);

    // Lanes disagree on the sync word, then a proper SOL line
    clear_stats();
    add_word(16'hA5C3, 16'hA5C2, 16, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    play(2);
    check_eq("t2_hunt_beats", n_beats, 0);
    check_eq("t2_hunt_active", line_active, 1'b0);
    add_line(2, -1, -1);
    play(2);
    drain();
    check_eq("t2_beats", n_beats, 8);
    check_eq("t2_tuser", n_user, 0);
    check_eq("t2_tlast", n_last, 1);

    // Backpressure across two pair completions: second pair dropped
    clear_stats();
    tready = 1'b0;
    add_line(1, -1, 1);
    play(2);
    drain();
    check_eq("t3_beats", n_beats, 6);
    check_eq("t3_tuser", n_user, 1);
    check_eq("t3_tlast", n_last, 1);
    check_eq("t3_overflow", overflow, 1'b1);

    // overflow_clr alone clears; together with a new drop the set wins
    ovf_clr = 1'b1;
    tick(); tick();
    check_eq("t3_clr", overflow, 1'b0);
    clear_stats();
    tready = 1'b0;
    add_line(2, 1, 1);
    play(2);
    drain();
    check_eq("t3b_overflow", overflow, 1'b1);
    check_eq("t3b_beats", n_beats, 6);
    check_eq("t3b_tlast", n_last, 1);

    // Reset while a beat is stalled
    tready = 1'b0;
    add_word(SOF, SOF, 16, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_pair(rnd_pix(), rnd_pix(), 1'b0, 1'b0, 1'b0);
    play(2);
    tick();
    check_eq("t4_pre_tvalid", tvalid, 1'b1);
    rst = 1'b1;
    tick();
    check_eq("t4_tvalid", tvalid, 1'b0);
    check_eq("t4_tdata", tdata, 16'h0);
    check_eq("t4_tuser", tuser, 1'b0);
    check_eq("t4_tlast", tlast, 1'b0);
    check_eq("t4_line_active", line_active, 1'b0);
    check_eq("t4_overflow", overflow, 1'b0);
    rst = 1'b0; tready = 1'b1;
    tick(); tick();

    // Enable dropped 3 bits into pixel pair 2 with pair 1 still held
    clear_stats();
    tready = 1'b0;
    add_word(SOF, SOF, 16, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_pair(rnd_pix(), rnd_pix(), 1'b0, 1'b0, 1'b0);
    add_word(rnd_pix(), rnd_pix(), 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    play(2);
    enable = 1'b0;
    tick();
    check_eq("t5_tvalid", tvalid, 1'b0);
    check_eq("t5_line_active", line_active, 1'b0);
    tready = 1'b1; enable = 1'b1;
    tick();
    add_garbage(40);
    play(2);
    check_eq("t5_no_beats", n_beats, 0);
    add_line(1, -1, -1);
    play(2);
    drain();
    check_eq("t5_beats", n_beats, 8);
    check_eq("t5_tuser", n_user, 1);

    // Two back-to-back lines with a strobe every cycle
    clear_stats();
    add_line(1, -1, -1);
    add_line(2, -1, -1);
    play(1);
    drain();
    check_eq("t6_beats", n_beats, 16);
    check_eq("t6_tuser", n_user, 1);
    check_eq("t6_tlast", n_last, 2);
    check_eq("t6_overflow", overflow, 1'b0);

    // Randomised lines, strobe gaps, ready and clears
    rdy_rand = 1'b1;
    for (int l = 0; l < 8; l++) begin
      int c;
      c = $urandom_range(0, 5);
      add_line($urandom_range(1, 2), (c < NP) ? c : -1, -1);
      play(0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
